prog_div_loader: RTL and testbench

Programmable integer clock-enable divider with a one-entry shadow register and valid/ready load port. It is the write side of the divider's ratio control path: the upstream controller (modulator or config logic) pushes new divide ratios, and the block applies each one only at a period boundary, so the output never sees a truncated or stretched period. It sits between the ratio source and the dual-modulus divider control logic, all in the `clk` domain.

---
 rtl/div_pkg.sv | 10 +
 rtl/ratio_shadow.sv | 56 +++++
 rtl/prog_div_loader.sv | 93 +++++++++
 tb/tb_prog_div_loader.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the divide-ratio control path.
// The loader and the dual-modulus divider control logic both use these.
package div_pkg;

    localparam int unsigned DIV_WIDTH     = 8;
    localparam int unsigned DIV_MIN_RATIO = 2;

    typedef logic [DIV_WIDTH-1:0] ratio_t;

endpackage

// File: rtl/ratio_shadow.sv
// One-entry shadow buffer for a pending divide ratio.
// Requests below the minimum are clamped, and a one-cycle error pulse is raised.
module ratio_shadow
    import div_pkg::*;
#(
    parameter int unsigned WIDTH     = DIV_WIDTH,
    parameter int unsigned MIN_RATIO = DIV_MIN_RATIO
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_clr,
    output logic             full,
    output logic [WIDTH-1:0] rd_data,
    output logic             err_clamp
);

    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_RATIO);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    // The top only writes when empty and only clears when full, so both never occur together.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        if (rd_clr) begin
            valid_d = 1'b0;
        end
        if (wr_en) begin
            valid_d = 1'b1;
            err_d   = (wr_data < MIN_W);
            data_d  = (wr_data < MIN_W) ? MIN_W : wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= MIN_W;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign full      = valid_q;
    assign rd_data   = data_q;
    assign err_clamp = err_q;

endmodule

// File: rtl/prog_div_loader.sv
// Programmable clock-enable divider. New ratios are staged in a shadow register
// and applied only at the terminal count, so no period is ever truncated or stretched.
module prog_div_loader
    import div_pkg::*;
#(
    parameter int unsigned WIDTH     = DIV_WIDTH,
    parameter int unsigned RST_RATIO = 4,
    parameter int unsigned MIN_RATIO = DIV_MIN_RATIO
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_ratio,
    output logic             in_ready,
    output logic             div_pulse,
    output logic             div_out,
    output logic [WIDTH-1:0] active_ratio,
    output logic             load_pulse,
    output logic             err_clamp
);

    localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_RATIO);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             div_pulse_q, div_pulse_d;
    logic             div_out_q, div_out_d;
    logic             load_pulse_q, load_pulse_d;

    logic             tc;
    logic             shadow_full;
    logic             shadow_apply;
    logic [WIDTH-1:0] shadow_data;

    assign tc           = (cnt_q == '0);
    assign shadow_apply = tc && shadow_full;

    ratio_shadow #(
        .WIDTH     (WIDTH),
        .MIN_RATIO (MIN_RATIO)
    ) u_shadow (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (in_valid && !shadow_full),
        .wr_data   (in_ratio),
        .rd_clr    (shadow_apply),
        .full      (shadow_full),
        .rd_data   (shadow_data),
        .err_clamp (err_clamp)
    );

    // Output flops are fed from next-state values so they line up with cnt_q.
    always_comb begin
        active_d     = active_q;
        cnt_d        = cnt_q - ONE_W;
        load_pulse_d = 1'b0;
        if (tc) begin
            if (shadow_full) begin
                active_d     = shadow_data;
                cnt_d        = shadow_data - ONE_W;
                load_pulse_d = 1'b1;
            end else begin
                cnt_d = active_q - ONE_W;
            end
        end
        div_pulse_d = (cnt_d == '0);
        div_out_d   = (cnt_d >= (active_d >> 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= RST_W - ONE_W;
            active_q     <= RST_W;
            div_pulse_q  <= 1'b0;
            div_out_q    <= 1'b1;
            load_pulse_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            div_pulse_q  <= div_pulse_d;
            div_out_q    <= div_out_d;
            load_pulse_q <= load_pulse_d;
        end
    end

    assign in_ready     = !shadow_full;
    assign div_pulse    = div_pulse_q;
    assign div_out      = div_out_q;
    assign active_ratio = active_q;
    assign load_pulse   = load_pulse_q;

endmodule

// File: tb/tb_prog_div_loader.sv
// Bench for prog_div_loader: directed scenarios plus random requests, checked
// against a period-position model of the divider.
module tb_prog_div_loader;

    localparam int WIDTH     = 8;
    localparam int RST_RATIO = 4;
    localparam int MIN_RATIO = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_ratio;
    logic             in_ready;
    logic             div_pulse;
    logic             div_out;
    logic [WIDTH-1:0] active_ratio;
    logic             load_pulse;
    logic             err_clamp;

    prog_div_loader #(
        .WIDTH     (WIDTH),
        .RST_RATIO (RST_RATIO),
        .MIN_RATIO (MIN_RATIO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ratio     (in_ratio),
        .in_ready     (in_ready),
        .div_pulse    (div_pulse),
        .div_out      (div_out),
        .active_ratio (active_ratio),
        .load_pulse   (load_pulse),
        .err_clamp    (err_clamp)
    );

    always #5 clk = ~clk;

    // Model: m_pos is the cycle index within the current period of length m_r.
    int m_r, m_pos, m_sv, m_sh, m_load, m_err;
    int last_acc;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_r = RST_RATIO; m_pos = 0; m_sv = 0; m_sh = 0; m_load = 0; m_err = 0;
    endtask

    task automatic check_all();
        check("in_ready",     32'(in_ready),     32'(m_sv == 0));
        check("div_pulse",    32'(div_pulse),    32'(m_pos == m_r - 1));
        check("div_out",      32'(div_out),      32'(m_pos < (m_r + 1) / 2));
        check("active_ratio", 32'(active_ratio), 32'(m_r));
        check("load_pulse",   32'(load_pulse),   32'(m_load));
        check("err_clamp",    32'(err_clamp),    32'(m_err));
    endtask

    // One clock: model advances on the edge using the inputs held across it.
    task automatic step();
        int acc;
        @(posedge clk);
        acc = (in_valid === 1'b1) && (m_sv == 0);
        if (m_pos == m_r - 1) begin
            m_pos  = 0;
            m_load = m_sv;
            if (m_sv != 0) begin
                m_r  = m_sh;
                m_sv = 0;
            end
        end else begin
            m_pos  = m_pos + 1;
            m_load = 0;
        end
        m_err = 0;
        if (acc != 0) begin
            m_sv  = 1;
            m_sh  = (int'(in_ratio) < MIN_RATIO) ? MIN_RATIO : int'(in_ratio);
            m_err = (int'(in_ratio) < MIN_RATIO) ? 1 : 0;
        end
        last_acc = acc;
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Offer a ratio and hold it stable until accepted (bounded).
    task automatic offer(input int r);
        int ok;
        ok = 0;
        in_valid = 1'b1;
        in_ratio = WIDTH'(r);
        for (int i = 0; i < 600 && ok == 0; i++) begin
            step();
            ok = last_acc;
        end
        in_valid = 1'b0;
        check("offer_accepted", 32'(ok), 32'd1);
    endtask

    initial begin
        int ok;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_ratio = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Idle: RST_RATIO period, 1,1,0,0.
        run(13);

        // Load 7 mid-period.
        run(1);
        offer(7);
        run(16);

        // Load 5, then 9 while the shadow is still full.
        offer(5);
        offer(9);
        run(14);

        // Accept on the TC edge: 3 must wait for the following TC.
        ok = 0;
        for (int i = 0; i < 600 && ok == 0; i++) begin
            if (m_pos == m_r - 1 && m_sv == 0) ok = 1;
            else step();
        end
        check("tc_align_found", 32'(ok), 32'd1);
        in_valid = 1'b1;
        in_ratio = 8'd3;
        step();
        in_valid = 1'b0;
        check("tc_accept", 32'(last_acc), 32'd1);
        run(16);

        // Clamped requests.
        offer(0);
        run(3);
        offer(1);
        run(8);

        // Reset mid-period with a pending word.
        offer(6);
        run(1);
        check("shadow_full_before_rst", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        run(10);

        // Maximum ratio, no overflow.
        offer(255);
        run(300);

        // Random requests held until accepted.
        for (int i = 0; i < 800; i++) begin
            if (in_valid === 1'b1 && last_acc != 0) in_valid = 1'b0;
            if (in_valid === 1'b0 && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b1;
                in_ratio = WIDTH'($urandom_range(0, 12));
            end
            step();
        end
        in_valid = 1'b0;
        run(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
